// File: rtl/dfd_cla_pkg.sv
// rtl/dfd_cla_pkg.sv - shared CLA widths, action codes, EAP modes, FSM states and CSR layout
package dfd_cla_pkg;

    localparam int CLA_NUMBER_OF_EVENTS         = 16;
    localparam int CLA_EVENT_SEL_W              = 4;
    localparam int CLA_NODE_ID_MSB              = 1;
    localparam int CLA_MAX_SEL                  = 4;
    localparam int CLA_THRESH_W                 = 32;
    localparam int CLA_NUMBER_OF_ACTIONS        = 8;
    localparam int CLA_ACTION_W                 = 3;
    localparam int CLA_NUMBER_OF_CUSTOM_ACTIONS = 4;
    localparam int CLA_CUSTOM_ACTION_W          = 2;

    localparam logic [CLA_ACTION_W-1:0] ACTION_DEBUG_INTERRUPT = 3'd1;

    localparam logic [1:0] EAP_MODE_LEVEL  = 2'b00;
    localparam logic [1:0] EAP_MODE_EDGE   = 2'b01;
    localparam logic [1:0] EAP_MODE_COUNT  = 2'b10;
    localparam logic [1:0] EAP_MODE_CONSEC = 2'b11;

    typedef enum logic {
        EAP_IDLE  = 1'b0,
        EAP_ARMED = 1'b1
    } eap_state_e;

    // Sized for the largest selector count / counter; nodes use the low slices.
    typedef struct packed {
        logic [CLA_MAX_SEL-1:0][CLA_EVENT_SEL_W-1:0] EventType;
        logic [(2**CLA_MAX_SEL)-1:0]                 Lut;
        logic [1:0]                                  Mode;
        logic [CLA_THRESH_W-1:0]                     Threshold;
        logic [CLA_ACTION_W-1:0]                     Action0;
        logic [CLA_ACTION_W-1:0]                     Action1;
        logic [CLA_ACTION_W-1:0]                     Action2;
        logic [CLA_ACTION_W-1:0]                     Action3;
        logic [CLA_CUSTOM_ACTION_W-1:0]              CustomAction0;
        logic [CLA_CUSTOM_ACTION_W-1:0]              CustomAction1;
        logic                                        CustomAction0Enable;
        logic                                        CustomAction1Enable;
        logic [CLA_NODE_ID_MSB:0]                    DestNode;
    } NodeEapCtrCsr_s;

endpackage

// File: rtl/dfd_cla_eap_occ_ctr.sv
// rtl/dfd_cla_eap_occ_ctr.sv - saturating occurrence counter with threshold compare
module dfd_cla_eap_occ_ctr #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             run,
    input  logic             consec,
    input  logic             match,
    input  logic [CNT_W-1:0] threshold,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W:0]   count_inc;
    logic [CNT_W:0]   thr_eff;

    // One extra bit keeps the compare exact when the counter is all-ones.
    assign count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
    assign thr_eff   = (threshold == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, threshold};
    assign hit       = match && (count_inc >= thr_eff);
    assign count     = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (run) begin
            if (hit) begin
                count_d = '0;
            end else if (match) begin
                count_d = (&count_q) ? count_q : count_inc[CNT_W-1:0];
            end else if (consec) begin
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dfd_cla_node_eap_ctr.sv
// rtl/dfd_cla_node_eap_ctr.sv - per-node event/action point: event LUT, fire modes, sticky status
module dfd_cla_node_eap_ctr
    import dfd_cla_pkg::*;
#(
    parameter int MY_NODE_ID = 0,
    parameter int NUM_SEL    = 3,
    parameter int CNT_W      = 16
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic                                    enable_eap,
    input  logic [CLA_NUMBER_OF_EVENTS-1:0]         event_bus,
    input  NodeEapCtrCsr_s                          NodeEapCtrCsr,
    input  logic [CLA_NODE_ID_MSB:0]                current_node_id,
    input  logic                                    eap_status_w2c,
    output logic [CLA_NUMBER_OF_ACTIONS-1:0]        next_node_action_bus,
    output logic [CLA_NUMBER_OF_CUSTOM_ACTIONS-1:0] next_node_custom_action_bus,
    output logic                                    next_node_custom_action_bus_enable,
    output logic [CLA_NODE_ID_MSB:0]                next_destination_node_id,
    output logic                                    eap_fire,
    output logic                                    eap_status,
    output logic                                    reset_eap_status_w2c,
    output logic [CNT_W-1:0]                        eap_count
);

    localparam logic [CLA_NODE_ID_MSB:0] MY_ID = MY_NODE_ID[CLA_NODE_ID_MSB:0];

    eap_state_e       state_q, state_d;
    logic [NUM_SEL-1:0] sel_hit;
    logic             match, active, armed_live, leaving, mode_chg, cnt_hit, dbg_sel, w2c_rise;
    logic             match_q, match_d, irq_q, irq_d, status_q, status_d, w2c_q, w2c_d;
    logic [1:0]       mode_q, mode_d;
    logic             unused_csr;

    assign unused_csr = ^NodeEapCtrCsr;

    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < NUM_SEL; k++) begin
            sel_hit[k] = event_bus[NodeEapCtrCsr.EventType[k]];
        end
    end

    assign match      = NodeEapCtrCsr.Lut[sel_hit];
    assign active     = enable_eap && (current_node_id == MY_ID);
    assign armed_live = (state_q == EAP_ARMED) && active;
    assign leaving    = (state_q == EAP_ARMED) && !active;
    assign mode_chg   = (state_q == EAP_ARMED) && (NodeEapCtrCsr.Mode != mode_q);
    assign w2c_rise   = eap_status_w2c && !w2c_q;
    assign dbg_sel    = (NodeEapCtrCsr.Action0 == ACTION_DEBUG_INTERRUPT) ||
                        (NodeEapCtrCsr.Action1 == ACTION_DEBUG_INTERRUPT) ||
                        (NodeEapCtrCsr.Action2 == ACTION_DEBUG_INTERRUPT) ||
                        (NodeEapCtrCsr.Action3 == ACTION_DEBUG_INTERRUPT);

    dfd_cla_eap_occ_ctr #(.CNT_W(CNT_W)) u_occ_ctr (
        .clock     (clock),
        .reset_n   (reset_n),
        .clr       (leaving || mode_chg),
        .run       (armed_live && NodeEapCtrCsr.Mode[1]),
        .consec    (NodeEapCtrCsr.Mode == EAP_MODE_CONSEC),
        .match     (match),
        .threshold (NodeEapCtrCsr.Threshold[CNT_W-1:0]),
        .count     (eap_count),
        .hit       (cnt_hit)
    );

    always_comb begin
        state_d  = active ? EAP_ARMED : EAP_IDLE;
        eap_fire = 1'b0;
        case (NodeEapCtrCsr.Mode)
            EAP_MODE_LEVEL: eap_fire = armed_live && match;
            EAP_MODE_EDGE:  eap_fire = armed_live && match && !match_q;
            default:        eap_fire = armed_live && cnt_hit;
        endcase
        // match_q only tracks while armed so the first armed match counts as an edge.
        match_d  = armed_live ? match : 1'b0;
        irq_d    = (eap_fire && dbg_sel) || (irq_q && !w2c_rise);
        status_d = eap_fire || (status_q && !w2c_rise);
        w2c_d    = eap_status_w2c;
        mode_d   = NodeEapCtrCsr.Mode;
    end

    always_comb begin
        next_node_action_bus = '0;
        for (int i = 0; i < CLA_NUMBER_OF_ACTIONS; i++) begin
            next_node_action_bus[i] = eap_fire &&
                ((NodeEapCtrCsr.Action0 == CLA_ACTION_W'(i)) ||
                 (NodeEapCtrCsr.Action1 == CLA_ACTION_W'(i)) ||
                 (NodeEapCtrCsr.Action2 == CLA_ACTION_W'(i)) ||
                 (NodeEapCtrCsr.Action3 == CLA_ACTION_W'(i)));
        end
        next_node_action_bus[ACTION_DEBUG_INTERRUPT] =
            next_node_action_bus[ACTION_DEBUG_INTERRUPT] || irq_q;
        next_node_custom_action_bus = '0;
        for (int i = 0; i < CLA_NUMBER_OF_CUSTOM_ACTIONS; i++) begin
            next_node_custom_action_bus[i] = eap_fire &&
                ((NodeEapCtrCsr.CustomAction0Enable &&
                  (NodeEapCtrCsr.CustomAction0 == CLA_CUSTOM_ACTION_W'(i))) ||
                 (NodeEapCtrCsr.CustomAction1Enable &&
                  (NodeEapCtrCsr.CustomAction1 == CLA_CUSTOM_ACTION_W'(i))));
        end
    end

    assign next_node_custom_action_bus_enable = NodeEapCtrCsr.CustomAction0Enable ||
                                                NodeEapCtrCsr.CustomAction1Enable;
    assign next_destination_node_id = eap_fire ? NodeEapCtrCsr.DestNode : MY_ID;
    assign eap_status               = status_q;
    assign reset_eap_status_w2c     = w2c_rise;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= EAP_IDLE;
            match_q  <= 1'b0;
            irq_q    <= 1'b0;
            status_q <= 1'b0;
            w2c_q    <= 1'b0;
            mode_q   <= EAP_MODE_LEVEL;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            irq_q    <= irq_d;
            status_q <= status_d;
            w2c_q    <= w2c_d;
            mode_q   <= mode_d;
        end
    end

endmodule

// File: tb/tb_dfd_cla_node_eap_ctr.sv
// tb/tb_dfd_cla_node_eap_ctr.sv - directed and random checks of the node EAP against a reference model
module tb_dfd_cla_node_eap_ctr;
    import dfd_cla_pkg::*;

    localparam int MY = 1;
    localparam int NS = 3;
    localparam int CW = 16;

    logic                                    clock;
    logic                                    reset_n;
    logic                                    enable_eap;
    logic [CLA_NUMBER_OF_EVENTS-1:0]         event_bus;
    NodeEapCtrCsr_s                          csr;
    logic [CLA_NODE_ID_MSB:0]                current_node_id;
    logic                                    eap_status_w2c;
    logic [CLA_NUMBER_OF_ACTIONS-1:0]        act_bus;
    logic [CLA_NUMBER_OF_CUSTOM_ACTIONS-1:0] cust_bus;
    logic                                    cust_en;
    logic [CLA_NODE_ID_MSB:0]                dest;
    logic                                    eap_fire;
    logic                                    eap_status;
    logic                                    rst_pulse;
    logic [CW-1:0]                           eap_count;

    dfd_cla_node_eap_ctr #(.MY_NODE_ID(MY), .NUM_SEL(NS), .CNT_W(CW)) dut (
        .clock                              (clock),
        .reset_n                            (reset_n),
        .enable_eap                         (enable_eap),
        .event_bus                          (event_bus),
        .NodeEapCtrCsr                      (csr),
        .current_node_id                    (current_node_id),
        .eap_status_w2c                     (eap_status_w2c),
        .next_node_action_bus               (act_bus),
        .next_node_custom_action_bus        (cust_bus),
        .next_node_custom_action_bus_enable (cust_en),
        .next_destination_node_id           (dest),
        .eap_fire                           (eap_fire),
        .eap_status                         (eap_status),
        .reset_eap_status_w2c               (rst_pulse),
        .eap_count                          (eap_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int fire_cnt = 0;
    int fire_at  = -1;
    int cyc_idx  = 0;

    bit m_armed, m_prev, m_status, m_irq, m_w2c_prev;
    int m_cnt;
    int m_mode_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_match();
        int idx = 0;
        for (int k = 0; k < NS; k++)
            if (event_bus[csr.EventType[k]]) idx += (1 << k);
        return csr.Lut[idx];
    endfunction

    function automatic bit selects(input int code);
        return (csr.Action0 == code) || (csr.Action1 == code) ||
               (csr.Action2 == code) || (csr.Action3 == code);
    endfunction

    task automatic model_reset();
        m_armed = 0; m_prev = 0; m_status = 0; m_irq = 0; m_w2c_prev = 0;
        m_cnt = 0; m_mode_prev = 0;
    endtask

    // One clock: outputs compared mid-cycle, then the reference advances past the edge.
    task automatic cycle();
        bit act, live, mt, fire, rise;
        int thr, mode, n_cnt;
        logic [7:0] ea;
        logic [3:0] ec;
        @(negedge clock);
        act  = enable_eap && (current_node_id == MY);
        live = m_armed && act;
        mt   = ref_match();
        thr  = int'(csr.Threshold[CW-1:0]);
        if (thr == 0) thr = 1;
        mode = int'(csr.Mode);
        if (!live)          fire = 0;
        else if (mode == 0) fire = mt;
        else if (mode == 1) fire = mt && !m_prev;
        else                fire = mt && (m_cnt + 1 >= thr);
        rise = eap_status_w2c && !m_w2c_prev;
        for (int i = 0; i < 8; i++) begin
            ea[i] = fire && selects(i);
            if (i == int'(ACTION_DEBUG_INTERRUPT)) ea[i] = ea[i] || m_irq;
        end
        for (int i = 0; i < 4; i++)
            ec[i] = fire && ((csr.CustomAction0Enable && csr.CustomAction0 == i) ||
                             (csr.CustomAction1Enable && csr.CustomAction1 == i));
        chk("eap_fire", eap_fire, fire);
        chk("action_bus", act_bus, ea);
        chk("custom_bus", cust_bus, ec);
        chk("custom_en", cust_en, csr.CustomAction0Enable || csr.CustomAction1Enable);
        chk("dest_node", dest, fire ? csr.DestNode : 2'(MY));
        chk("eap_status", eap_status, m_status);
        chk("w2c_pulse", rst_pulse, rise);
        chk("eap_count", eap_count, m_cnt);
        if (eap_fire === 1'b1) begin
            fire_cnt++;
            fire_at = cyc_idx;
        end
        cyc_idx++;
        n_cnt = m_cnt;
        if (m_armed && (!act || mode != m_mode_prev)) n_cnt = 0;
        else if (live && mode >= 2) begin
            if (fire)           n_cnt = 0;
            else if (mt)        n_cnt = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
            else if (mode == 3) n_cnt = 0;
        end
        @(posedge clock);
        #1;
        m_cnt       = n_cnt;
        m_prev      = live ? mt : 0;
        m_armed     = act;
        m_irq       = (fire && selects(int'(ACTION_DEBUG_INTERRUPT))) || (m_irq && !rise);
        m_status    = fire || (m_status && !rise);
        m_w2c_prev  = eap_status_w2c;
        m_mode_prev = mode;
    endtask

    task automatic apply_reset();
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_count", eap_count, 0);
        chk("rst_status", eap_status, 0);
        chk("rst_fire", eap_fire, 0);
        chk("rst_actions", act_bus, 0);
        chk("rst_custom", cust_bus, 0);
        chk("rst_pulse", rst_pulse, 0);
        chk("rst_dest", dest, MY);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic set_match(input bit m);
        event_bus = m ? 16'h1088 : 16'h0000;
    endtask

    task automatic window_start();
        fire_cnt = 0; fire_at = -1; cyc_idx = 0;
    endtask

    initial begin
        reset_n         = 1'b1;
        enable_eap      = 1'b1;
        current_node_id = 2'(MY);
        eap_status_w2c  = 1'b0;
        event_bus       = '0;
        csr             = '0;
        csr.EventType[0] = 4'd3;
        csr.EventType[1] = 4'd7;
        csr.EventType[2] = 4'd12;
        csr.Lut          = 16'h0080;
        csr.Mode         = EAP_MODE_LEVEL;
        csr.Action0      = 3'd3;
        csr.Action1      = 3'd5;
        csr.Action2      = 3'd3;
        csr.Action3      = 3'd3;
        csr.CustomAction0       = 2'd2;
        csr.CustomAction0Enable = 1'b1;
        csr.CustomAction1       = 2'd1;
        csr.DestNode     = 2'd3;
        @(posedge clock);
        apply_reset();
        repeat (2) cycle();

        // LEVEL: three cycles of match give three fires and sticky status
        window_start();
        set_match(1); repeat (3) cycle();
        set_match(0); cycle();
        chk("level_fires", fire_cnt, 3);
        chk("level_status", eap_status, 1);
        eap_status_w2c = 1'b1; cycle();
        eap_status_w2c = 1'b0; cycle();
        chk("level_cleared", eap_status, 0);

        // EDGE: held match fires once
        csr.Mode = EAP_MODE_EDGE; cycle();
        window_start();
        set_match(1); repeat (5) cycle();
        set_match(0); cycle();
        chk("edge_fires", fire_cnt, 1);

        // COUNT threshold 4, match at 0,2,5,9
        csr.Mode = EAP_MODE_COUNT; csr.Threshold = 32'd4; cycle();
        window_start();
        for (int c = 0; c < 10; c++) begin
            set_match(c == 0 || c == 2 || c == 5 || c == 9);
            cycle();
        end
        set_match(0); cycle();
        chk("count_fire_at", fire_at, 9);
        chk("count_fires", fire_cnt, 1);
        chk("count_after", eap_count, 0);

        // CONSEC threshold 3, pattern 1,1,0,1,1,1
        csr.Mode = EAP_MODE_CONSEC; csr.Threshold = 32'd3; cycle();
        window_start();
        for (int c = 0; c < 6; c++) begin
            set_match(c != 2);
            cycle();
        end
        set_match(0); cycle();
        chk("consec_fire_at", fire_at, 5);
        chk("consec_fires", fire_cnt, 1);

        // Node moves away mid-count
        eap_status_w2c = 1'b1; cycle();
        eap_status_w2c = 1'b0;
        csr.Mode = EAP_MODE_COUNT; csr.Threshold = 32'd4; cycle();
        window_start();
        set_match(1); repeat (2) cycle();
        chk("away_count2", eap_count, 2);
        current_node_id = 2'd0; repeat (2) cycle();
        set_match(0); cycle();
        chk("away_count", eap_count, 0);
        chk("away_fires", fire_cnt, 0);
        chk("away_status", eap_status, 0);
        current_node_id = 2'(MY); repeat (2) cycle();

        // Debug interrupt vs simultaneous w2c
        csr.Mode = EAP_MODE_LEVEL; csr.Action0 = ACTION_DEBUG_INTERRUPT; cycle();
        set_match(1); cycle();
        set_match(0); cycle();
        chk("irq_held", act_bus[ACTION_DEBUG_INTERRUPT], 1);
        set_match(1); eap_status_w2c = 1'b1; cycle();
        set_match(0); eap_status_w2c = 1'b0; cycle();
        chk("irq_kept", act_bus[ACTION_DEBUG_INTERRUPT], 1);
        chk("status_kept", eap_status, 1);
        eap_status_w2c = 1'b1; cycle();
        eap_status_w2c = 1'b0; cycle();
        chk("irq_cleared", act_bus[ACTION_DEBUG_INTERRUPT], 0);
        chk("status_cleared", eap_status, 0);

        // Reset discards a partial count
        csr.Mode = EAP_MODE_COUNT; csr.Threshold = 32'd5; cycle();
        set_match(1); repeat (3) cycle();
        chk("pre_reset_count", eap_count, 3);
        apply_reset();
        chk("post_reset_count", eap_count, 0);
        set_match(0); cycle();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if (n % 25 == 0) begin
                csr.Mode      = 2'($urandom_range(0, 3));
                csr.Lut       = 16'($urandom_range(0, 255));
                csr.Threshold = 32'($urandom_range(0, 5));
                for (int k = 0; k < NS; k++) csr.EventType[k] = 4'($urandom_range(0, 15));
                csr.Action0 = 3'($urandom_range(0, 7));
                csr.Action1 = 3'($urandom_range(0, 7));
                csr.CustomAction0       = 2'($urandom_range(0, 3));
                csr.CustomAction1       = 2'($urandom_range(0, 3));
                csr.CustomAction0Enable = 1'($urandom_range(0, 1));
                csr.CustomAction1Enable = 1'($urandom_range(0, 1));
                csr.DestNode            = 2'($urandom_range(0, 3));
            end
            event_bus       = 16'($urandom);
            enable_eap      = ($urandom_range(0, 9) != 0);
            current_node_id = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'(MY);
            eap_status_w2c  = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
